// File: rtl/mtl2_pixel_out_if.sv
// Avalon-ST pixel stream between the frame-buffer reader and the MTL2 panel back-end.
// Beat = {R[23:16], G[15:8], B[7:0]}; a beat transfers on a rising edge with valid & ready.
interface mtl2_pixel_out_if;
    logic [23:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ready;

    // Pixel source (frame-buffer reader side)
    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        input  ready
    );

    // Pixel sink (panel back-end side)
    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        output ready
    );
endinterface

// File: rtl/mtl2_pixel_out.sv
// MTL2 panel back-end: generates 800x480 panel timing, locks each frame to the incoming
// stream's startofpacket and drives registered HSD/VSD/DE/RGB. On underflow the rest of the
// frame is blanked (and counted); on framing errors the block drops lock and waits for the
// next startofpacket, which is only accepted at pixel (0,0).
module mtl2_pixel_out #(
    parameter int unsigned HActive   = 800,
    parameter int unsigned HFp       = 210,
    parameter int unsigned HSync     = 30,
    parameter int unsigned HBp       = 16,
    parameter int unsigned VActive   = 480,
    parameter int unsigned VFp       = 22,
    parameter int unsigned VSync     = 13,
    parameter int unsigned VBp       = 10,
    parameter logic [23:0] FillColor = 24'h000000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    mtl2_pixel_out_if.slave sink_io,
    output logic [7:0]      mtl2_r_o,
    output logic [7:0]      mtl2_g_o,
    output logic [7:0]      mtl2_b_o,
    output logic            mtl2_hsd_o,
    output logic            mtl2_vsd_o,
    output logic            mtl2_de_o,
    output logic            frame_start_o,
    output logic [15:0]     underflow_cnt_o,
    output logic            locked_o
);

    localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
    localparam int unsigned VTotal = VActive + VFp + VSync + VBp;
    localparam int unsigned HCntW  = $clog2(HTotal);
    localparam int unsigned VCntW  = $clog2(VTotal);

    localparam logic [HCntW-1:0] HActLast = HCntW'(HActive - 1);
    localparam logic [HCntW-1:0] HSyncBeg = HCntW'(HActive + HFp);
    localparam logic [HCntW-1:0] HSyncEnd = HCntW'(HActive + HFp + HSync);
    localparam logic [HCntW-1:0] HLast    = HCntW'(HTotal - 1);
    localparam logic [VCntW-1:0] VActLast = VCntW'(VActive - 1);
    localparam logic [VCntW-1:0] VSyncBeg = VCntW'(VActive + VFp);
    localparam logic [VCntW-1:0] VSyncEnd = VCntW'(VActive + VFp + VSync);
    localparam logic [VCntW-1:0] VLast    = VCntW'(VTotal - 1);

    typedef enum logic [1:0] {
        StWaitSop,
        StActive,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [HCntW-1:0] hcnt_q, hcnt_d;
    logic [VCntW-1:0] vcnt_q, vcnt_d;
    logic             hsd_q;
    logic             vsd_q;
    logic             de_q;
    logic             frame_start_q;
    logic [23:0]      rgb_q;
    logic [15:0]      underflow_cnt_q;

    logic             vis;
    logic             at_origin;
    logic             at_last;
    logic             at_end;
    logic             hsync_n;
    logic             vsync_n;
    logic             frame_err;
    logic             ready;
    logic             take_beat;
    logic             underflow;
    logic [23:0]      pixel;

    // Raster counters: hcnt wraps at the end of each line and advances vcnt.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    // Position decodes for the pixel currently addressed by the counters.
    always_comb begin
        vis       = (hcnt_q <= HActLast) && (vcnt_q <= VActLast);
        at_origin = (hcnt_q == '0) && (vcnt_q == '0);
        at_last   = (hcnt_q == HActLast) && (vcnt_q == VActLast);
        at_end    = (hcnt_q == HLast) && (vcnt_q == VLast);
        hsync_n   = !((hcnt_q >= HSyncBeg) && (hcnt_q < HSyncEnd));
        vsync_n   = !((vcnt_q >= VSyncBeg) && (vcnt_q < VSyncEnd));
        // sop belongs exactly at (0,0); eop may only appear on the last visible pixel.
        frame_err = (sink_io.sop != at_origin) || (sink_io.eop && !at_last);
    end

    // Lock state decisions: stream handshake, beat use, underflow and next state.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        take_beat = 1'b0;
        underflow = 1'b0;
        unique case (state_q)
            StWaitSop: begin
                // Discard stray beats; hold an sop beat until the raster reaches (0,0).
                ready = !sink_io.sop || at_origin;
                if (at_origin && sink_io.valid && sink_io.sop) begin
                    take_beat = 1'b1;
                    state_d   = StActive;
                end
            end
            StActive: begin
                if (vis) begin
                    // A misplaced beat is refused so it can start the next frame.
                    ready = !frame_err;
                    if (!sink_io.valid) begin
                        underflow = 1'b1;
                        state_d   = StDrain;
                    end else if (frame_err) begin
                        state_d = StWaitSop;
                    end else begin
                        take_beat = 1'b1;
                    end
                end
            end
            StDrain: begin
                underflow = vis;
                if (at_end) begin
                    state_d = StWaitSop;
                end
            end
            default: begin
                state_d = StWaitSop;
            end
        endcase
        if (reset_i || !enable_i) begin
            ready     = 1'b0;
            take_beat = 1'b0;
            underflow = 1'b0;
            state_d   = StWaitSop;
        end
    end

    // Colour for the current pixel: stream data when a beat is used, fill otherwise.
    always_comb begin
        if (!vis) begin
            pixel = 24'h000000;
        end else if (take_beat) begin
            pixel = sink_io.data;
        end else begin
            pixel = FillColor;
        end
    end

    assign sink_io.ready = ready;

    // State, counters and the registered pin stage (one pixel of latency).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StWaitSop;
            hcnt_q          <= '0;
            vcnt_q          <= '0;
            hsd_q           <= 1'b1;
            vsd_q           <= 1'b1;
            de_q            <= 1'b0;
            rgb_q           <= 24'h000000;
            frame_start_q   <= 1'b0;
            underflow_cnt_q <= 16'h0000;
        end else if (!enable_i) begin
            // Idle: raster parked at (0,0); the underflow count survives.
            state_q       <= StWaitSop;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsd_q         <= 1'b1;
            vsd_q         <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= 24'h000000;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsd_q         <= hsync_n;
            vsd_q         <= vsync_n;
            de_q          <= vis;
            rgb_q         <= pixel;
            frame_start_q <= at_origin;
            if (underflow && (underflow_cnt_q != 16'hFFFF)) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end
        end
    end

    assign mtl2_r_o        = rgb_q[23:16];
    assign mtl2_g_o        = rgb_q[15:8];
    assign mtl2_b_o        = rgb_q[7:0];
    assign mtl2_hsd_o      = hsd_q;
    assign mtl2_vsd_o      = vsd_q;
    assign mtl2_de_o       = de_q;
    assign frame_start_o   = frame_start_q;
    assign underflow_cnt_o = underflow_cnt_q;
    assign locked_o        = (state_q == StActive);

endmodule
